// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants, frame state encoding and helpers for the
// PS/2 receive controller.
// Ports: none (package).
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int         PS2_FRAME_BITS = 11;
  // start + parity + stop surround the data bits
  localparam int         PS2_DATA_BITS  = PS2_FRAME_BITS - 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } frame_state_t;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

endpackage

// File: rtl/ps2_rx_ctrl_if.sv
// ps2_rx_ctrl_if: scan-code event channel (valid/ready holding register).
// Signals: code[7:0], code_ext, code_brk, code_valid from the controller;
//          code_ready from the consumer.
interface ps2_rx_ctrl_if;
  logic [7:0] code;
  logic       code_ext;
  logic       code_brk;
  logic       code_valid;
  logic       code_ready;

  modport master (output code, code_ext, code_brk, code_valid, input code_ready);
  modport slave  (input code, code_ext, code_brk, code_valid, output code_ready);
endinterface

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-FF synchronisers for the raw PS/2 clock and data lines
// plus a registered falling-edge detector on the synced clock.
// Ports: clk, rst (sync, active-high), kbclk/kbdata (async pins),
//        fe (one-cycle falling-edge strobe), data (synced data aligned to fe).
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic kbclk,
  input  logic kbdata,
  output logic fe,
  output logic data
);

  logic clk_s1, clk_s2, clk_prev;
  logic dat_s1, dat_s2;

  // data is registered alongside fe so the sampled bit lines up with the strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_s1   <= 1'b0;
      clk_s2   <= 1'b0;
      clk_prev <= 1'b0;
      dat_s1   <= 1'b0;
      dat_s2   <= 1'b0;
      fe       <= 1'b0;
      data     <= 1'b0;
    end else begin
      clk_s1   <= kbclk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= kbdata;
      dat_s2   <= dat_s1;
      fe       <= clk_prev & ~clk_s2;
      data     <= dat_s2;
    end
  end

endmodule

// File: rtl/ps2_rx_ctrl.sv
// ps2_rx_ctrl: host-side PS/2 keyboard receiver. Frames 11-bit packets with
// start/parity/stop checks and an inter-edge watchdog, folds E0/F0 prefixes
// into single events and presents them through a valid/ready holding register.
// Ports: clk, rst (sync, active-high), kbclk/kbdata (raw pins),
//        evt (event channel, master side), frame_err (error pulse),
//        overrun (dropped-event pulse), busy (frame in progress).
//
// state  | meaning
// IDLE   | waiting for a start bit (fe with data 0)
// DATA   | shifting in 8 data bits, LSB first
// PARITY | waiting for the parity bit
// STOP   | waiting for the stop bit, then check and emit
module ps2_rx_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            kbclk,
  input  logic            kbdata,
  ps2_rx_ctrl_if.master   evt,
  output logic            frame_err,
  output logic            overrun,
  output logic            busy
);

  localparam int            CW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    BIT_LAST = 3'(PS2_DATA_BITS - 1);

  logic fe, kd;

  ps2_sync_edge u_sync (
    .clk    (clk),
    .rst    (rst),
    .kbclk  (kbclk),
    .kbdata (kbdata),
    .fe     (fe),
    .data   (kd)
  );

  frame_state_t  state, state_n;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [CW-1:0] to_cnt;
  logic          ext_f, brk_f;
  logic          byte_emit, stop_err, to_hit, evt_new;

  always_comb begin
    state_n   = state;
    byte_emit = 1'b0;
    stop_err  = 1'b0;
    to_hit    = 1'b0;
    case (state)
      IDLE:   if (fe && !kd) state_n = DATA;
      DATA:   if (fe && bit_cnt == BIT_LAST) state_n = PARITY;
      PARITY: if (fe) state_n = STOP;
      STOP: begin
        if (fe) begin
          state_n = IDLE;
          if (kd && odd_parity_ok(shreg, par_bit)) byte_emit = 1'b1;
          else                                     stop_err  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    // watchdog: an fe in the same cycle wins over the timeout
    if (state != IDLE && !fe && to_cnt == TO_LAST) begin
      to_hit  = 1'b1;
      state_n = IDLE;
    end
  end

  assign evt_new = byte_emit && shreg != PS2_PREFIX_EXT && shreg != PS2_PREFIX_BRK;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'd0;
      par_bit   <= 1'b0;
      to_cnt    <= '0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      frame_err <= stop_err | to_hit;
      if (fe) begin
        case (state)
          IDLE:   bit_cnt <= 3'd0;
          DATA: begin
            shreg   <= {kd, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          PARITY: par_bit <= kd;
          default: ;
        endcase
      end
      if (state == IDLE || fe)  to_cnt <= '0;
      else if (to_cnt != TO_LAST) to_cnt <= to_cnt + CW'(1);
    end
  end

  // prefix flags survive frame errors and timeouts; only a real event clears them
  always_ff @(posedge clk) begin
    if (rst) begin
      ext_f <= 1'b0;
      brk_f <= 1'b0;
    end else if (byte_emit) begin
      if (shreg == PS2_PREFIX_EXT)      ext_f <= 1'b1;
      else if (shreg == PS2_PREFIX_BRK) brk_f <= 1'b1;
      else begin
        ext_f <= 1'b0;
        brk_f <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      evt.code       <= 8'd0;
      evt.code_ext   <= 1'b0;
      evt.code_brk   <= 1'b0;
      evt.code_valid <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (evt_new) begin
        if (!evt.code_valid || evt.code_ready) begin
          evt.code       <= shreg;
          evt.code_ext   <= ext_f;
          evt.code_brk   <= brk_f;
          evt.code_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (evt.code_ready) begin
        evt.code_valid <= 1'b0;
      end
    end
  end

endmodule
